// File: rtl/rand_pkg.sv
// Shared definitions for the random-walk path: word width, parameter defaults
// and the saturating add used to keep the walk bounded.
package rand_pkg;

    localparam int unsigned RAND_W       = 32;
    localparam int unsigned DEF_PERIOD   = 16;
    localparam int unsigned DEF_DEPTH    = 8;
    localparam int          DEF_WALK_MIN = -512;
    localparam int          DEF_WALK_MAX = 511;

    // 33-bit signed sum so a 32-bit overflow can never wrap past the clamp.
    function automatic logic [RAND_W-1:0] sat_add32(
        input logic [RAND_W-1:0] a,
        input logic [RAND_W-1:0] b,
        input logic [RAND_W-1:0] lo,
        input logic [RAND_W-1:0] hi
    );
        logic signed [RAND_W:0] sum;
        logic signed [RAND_W:0] lo_x;
        logic signed [RAND_W:0] hi_x;
        sum  = {a[RAND_W-1], a} + {b[RAND_W-1], b};
        lo_x = {lo[RAND_W-1], lo};
        hi_x = {hi[RAND_W-1], hi};
        if (sum > hi_x) begin
            return hi;
        end else if (sum < lo_x) begin
            return lo;
        end else begin
            return sum[RAND_W-1:0];
        end
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; occupancy is tracked by an explicit counter
// and guards on push/pop are applied here so callers may strobe freely.
module sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           wdata_i,
    output logic [WIDTH-1:0]           head_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CntW'(DEPTH));

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign pop_ok  = pop_i & ~empty_o;
    assign push_ok = push_i & (~full_o | pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/rand_walk_buffer.sv
// Paced bounded random walk: every PERIOD enabled cycles one LFSR step is
// added to the walk and the new position is queued for the CPU to pop.
module rand_walk_buffer
    import rand_pkg::*;
#(
    parameter int unsigned PERIOD   = DEF_PERIOD,
    parameter int unsigned DEPTH    = DEF_DEPTH,
    parameter int          WALK_MIN = DEF_WALK_MIN,
    parameter int          WALK_MAX = DEF_WALK_MAX
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [RAND_W-1:0]          rand_in,
    input  logic                       enable,
    input  logic                       rd_en,
    input  logic                       clr_ovf,
    output logic [RAND_W-1:0]          rd_data,
    output logic                       rd_valid,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic [RAND_W-1:0]          walk
);

    localparam int unsigned TickW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    logic [TickW-1:0]  tick_q, tick_d;
    logic [RAND_W-1:0] walk_q, walk_d;
    logic              overflow_q, overflow_d;
    logic [RAND_W-1:0] walk_next;
    logic              sample;
    logic              drop;
    logic              fifo_full;
    logic              fifo_empty;

    assign sample    = enable & (tick_q == TickW'(PERIOD - 1));
    assign walk_next = sat_add32(walk_q, rand_in, RAND_W'(WALK_MIN), RAND_W'(WALK_MAX));

    // A full FIFO only loses the sample if nothing is popped in that cycle.
    assign drop = sample & fifo_full & ~rd_en;

    always_comb begin
        tick_d     = tick_q;
        walk_d     = walk_q;
        overflow_d = overflow_q;
        if (enable) begin
            tick_d = sample ? '0 : tick_q + TickW'(1);
        end
        if (sample) begin
            walk_d = walk_next;
        end
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clr_ovf) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tick_q     <= '0;
            walk_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            tick_q     <= tick_d;
            walk_q     <= walk_d;
            overflow_q <= overflow_d;
        end
    end

    sync_fifo #(
        .WIDTH (RAND_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push_i  (sample),
        .pop_i   (rd_en),
        .wdata_i (walk_next),
        .head_o  (rd_data),
        .count_o (count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign rd_valid = ~fifo_empty;
    assign overflow = overflow_q;
    assign walk     = walk_q;

endmodule

// File: tb/tb_rand_walk_buffer.sv
// Randomised and directed checks of rand_walk_buffer against a queue-based
// model of the walk, pacing and FIFO.
module tb_rand_walk_buffer;

    localparam int unsigned PERIOD   = 4;
    localparam int unsigned DEPTH    = 4;
    localparam int          WALK_MIN = -20;
    localparam int          WALK_MAX = 20;
    localparam int unsigned CntW     = $clog2(DEPTH+1);

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic [31:0]     rand_in = '0;
    logic            enable = 1'b0;
    logic            rd_en = 1'b0;
    logic            clr_ovf = 1'b0;
    logic [31:0]     rd_data;
    logic            rd_valid;
    logic [CntW-1:0] count;
    logic            overflow;
    logic [31:0]     walk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state.
    int     m_fifo[$];
    longint m_walk;
    int     m_enabled;
    bit     m_ovf;

    rand_walk_buffer #(
        .PERIOD   (PERIOD),
        .DEPTH    (DEPTH),
        .WALK_MIN (WALK_MIN),
        .WALK_MAX (WALK_MAX)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .rand_in  (rand_in),
        .enable   (enable),
        .rd_en    (rd_en),
        .clr_ovf  (clr_ovf),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .count    (count),
        .overflow (overflow),
        .walk     (walk)
    );

    always #5 clock = ~clock;

    function automatic void model_reset();
        m_fifo.delete();
        m_walk    = 0;
        m_enabled = 0;
        m_ovf     = 0;
    endfunction

    function automatic void model_clock();
        bit     fire;
        bit     popped;
        bit     was_full;
        longint sum;
        fire     = enable && ((m_enabled % PERIOD) == PERIOD - 1);
        popped   = rd_en && (m_fifo.size() != 0);
        was_full = (m_fifo.size() == DEPTH);
        if (enable) m_enabled++;
        if (popped) void'(m_fifo.pop_front());
        if (fire) begin
            sum = m_walk + longint'($signed(rand_in));
            if (sum > WALK_MAX)      m_walk = WALK_MAX;
            else if (sum < WALK_MIN) m_walk = WALK_MIN;
            else                     m_walk = sum;
        end
        if (fire && was_full && !popped) begin
            m_ovf = 1;
        end else begin
            if (fire) m_fifo.push_back(int'(m_walk));
            if (clr_ovf) m_ovf = 0;
        end
    endfunction

    function automatic logic [31:0] exp_head();
        return (m_fifo.size() != 0) ? 32'(m_fifo[0]) : 32'd0;
    endfunction

    task automatic step();
        @(posedge clock);
        model_clock();
        @(negedge clock);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset   = 1'b1;
        enable  = 1'b0;
        rd_en   = 1'b0;
        clr_ovf = 1'b0;
        rand_in = '0;
        model_reset();
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        vectors += 5;
        if (count !== '0) begin
            miscompares++; $display("FAIL reset_count got %0d want 0", count);
        end
        if (rd_valid !== 1'b0) begin
            miscompares++; $display("FAIL reset_valid got %b want 0", rd_valid);
        end
        if (rd_data !== '0) begin
            miscompares++; $display("FAIL reset_data got %h want 0", rd_data);
        end
        if (overflow !== 1'b0) begin
            miscompares++; $display("FAIL reset_ovf got %b want 0", overflow);
        end
        if (walk !== '0) begin
            miscompares++; $display("FAIL reset_walk got %h want 0", walk);
        end
    endtask

    // Constant steps: covers steady pacing, positive and negative clamping.
    task automatic test_const_step(input logic [31:0] step_val, input int cycles,
                                   input string name);
        do_reset();
        enable  = 1'b1;
        rand_in = step_val;
        for (int i = 0; i < cycles; i++) begin
            step();
            vectors += 4;
            if (walk !== 32'(m_walk)) begin
                miscompares++;
                $display("FAIL %s_walk cyc %0d got %0d want %0d", name, i, $signed(walk), m_walk);
            end
            if (count !== CntW'(m_fifo.size())) begin
                miscompares++;
                $display("FAIL %s_count cyc %0d got %0d want %0d", name, i, count, m_fifo.size());
            end
            if (rd_data !== exp_head()) begin
                miscompares++;
                $display("FAIL %s_data cyc %0d got %h want %h", name, i, rd_data, exp_head());
            end
            if (overflow !== m_ovf) begin
                miscompares++;
                $display("FAIL %s_ovf cyc %0d got %b want %b", name, i, overflow, m_ovf);
            end
        end
    endtask

    task automatic test_overflow_clear();
        test_const_step(32'd7, 20, "pos_clamp");
        vectors += 3;
        if (overflow !== 1'b1 || count !== CntW'(DEPTH) || walk !== 32'(WALK_MAX)) begin
            miscompares++;
            $display("FAIL sat_state got ovf=%b cnt=%0d walk=%0d want 1/%0d/%0d",
                     overflow, count, $signed(walk), DEPTH, WALK_MAX);
        end
        enable  = 1'b0;
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        if (overflow !== 1'b0) begin
            miscompares++; $display("FAIL clr_ovf got %b want 0", overflow);
        end
        if (count !== CntW'(DEPTH)) begin
            miscompares++; $display("FAIL clr_keep_count got %0d want %0d", count, DEPTH);
        end
    endtask

    task automatic test_full_pop_on_sample();
        int          guard;
        logic [31:0] second;
        do_reset();
        enable  = 1'b1;
        rand_in = 32'd1;
        guard   = 0;
        while (!(m_fifo.size() == DEPTH && (m_enabled % PERIOD) == PERIOD - 1) && guard < 100) begin
            step();
            guard++;
        end
        vectors++;
        if (guard >= 100) begin
            miscompares++; $display("FAIL full_setup timeout got %0d want full", count);
        end else begin
            second = 32'(m_fifo[1]);
            rd_en  = 1'b1;
            step();
            rd_en  = 1'b0;
            vectors += 3;
            if (count !== CntW'(DEPTH)) begin
                miscompares++; $display("FAIL full_pop_count got %0d want %0d", count, DEPTH);
            end
            if (overflow !== 1'b0) begin
                miscompares++; $display("FAIL full_pop_ovf got %b want 0", overflow);
            end
            if (rd_data !== second) begin
                miscompares++; $display("FAIL full_pop_head got %h want %h", rd_data, second);
            end
        end
    endtask

    task automatic test_empty_pop_and_pause();
        bit en_pat [9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        do_reset();
        rand_in = 32'd5;
        rd_en   = 1'b1;
        for (int i = 0; i < 9; i++) begin
            enable = en_pat[i];
            if (i >= 2) rd_en = 1'b0;
            step();
            vectors += 3;
            if (count !== CntW'(m_fifo.size())) begin
                miscompares++;
                $display("FAIL pause_count cyc %0d got %0d want %0d", i, count, m_fifo.size());
            end
            if (rd_valid !== (m_fifo.size() != 0)) begin
                miscompares++;
                $display("FAIL pause_valid cyc %0d got %b want %b", i, rd_valid, m_fifo.size() != 0);
            end
            if (rd_data !== exp_head()) begin
                miscompares++;
                $display("FAIL pause_data cyc %0d got %h want %h", i, rd_data, exp_head());
            end
        end
        vectors++;
        if (count !== CntW'(1)) begin
            miscompares++; $display("FAIL pause_one_sample got %0d want 1", count);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        enable  = 1'b1;
        rand_in = 32'd4;
        repeat (3 * PERIOD) step();
        @(negedge clock);
        #2 reset = 1'b1;
        #1;
        vectors += 4;
        if (count !== '0 || rd_valid !== 1'b0 || walk !== '0 || overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset got cnt=%0d val=%b walk=%0d ovf=%b want 0/0/0/0",
                     count, rd_valid, $signed(walk), overflow);
        end
        model_reset();
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < PERIOD; i++) begin
            step();
            vectors++;
            if (rd_valid !== (i == PERIOD - 1)) begin
                miscompares++;
                $display("FAIL post_reset_valid cyc %0d got %b want %b", i, rd_valid, i == PERIOD - 1);
            end
        end
        vectors++;
        if (walk !== 32'd4) begin
            miscompares++; $display("FAIL post_reset_walk got %0d want 4", $signed(walk));
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 800; i++) begin
            enable  = ($urandom % 4) != 0;
            rd_en   = ($urandom % 3) == 0;
            clr_ovf = ($urandom % 6) == 0;
            case ($urandom % 16)
                0:       rand_in = 32'h7FFF_FFFF;
                1:       rand_in = 32'h8000_0000;
                default: rand_in = 32'($signed(int'($urandom_range(14)) - 7));
            endcase
            step();
            vectors += 5;
            if (walk !== 32'(m_walk)) begin
                miscompares++;
                $display("FAIL rnd_walk cyc %0d got %0d want %0d", i, $signed(walk), m_walk);
            end
            if (count !== CntW'(m_fifo.size())) begin
                miscompares++;
                $display("FAIL rnd_count cyc %0d got %0d want %0d", i, count, m_fifo.size());
            end
            if (rd_valid !== (m_fifo.size() != 0)) begin
                miscompares++;
                $display("FAIL rnd_valid cyc %0d got %b want %b", i, rd_valid, m_fifo.size() != 0);
            end
            if (rd_data !== exp_head()) begin
                miscompares++;
                $display("FAIL rnd_data cyc %0d got %h want %h", i, rd_data, exp_head());
            end
            if (overflow !== m_ovf) begin
                miscompares++;
                $display("FAIL rnd_ovf cyc %0d got %b want %b", i, overflow, m_ovf);
            end
        end
    endtask

    initial begin
        test_reset();
        test_const_step(32'd3, 12, "steady");
        test_overflow_clear();
        test_const_step(32'hFFFF_FFF9, 16, "neg_clamp");
        test_full_pop_on_sample();
        test_empty_pop_and_pause();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
